decoder_n_seq: RTL and testbench
================================

DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 SHALL have parameter IN_W, default 3, select width; output width OUT_W = 2**IN_W (localparam).
REQ-002 SHALL have parameter DWELL, default 4, cycles each one-hot position is held in scan mode (min 1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  output gate; 0 forces out to all zeros.
REQ-006 SHALL have port mode  input  1  0 = direct decode, 1 = scan (auto-walk).
REQ-007 SHALL have port in  input  IN_W  select value.
REQ-008 SHALL have port in_valid  input  1  select offered.
REQ-009 SHALL have port in_ready  output  1  select accepted when in_valid & in_ready.
REQ-010 SHALL have port out  output  OUT_W  registered one-hot (or zero) decode.
REQ-011 SHALL have port out_valid  output  1  out holds a live one-hot value.
REQ-012 SHALL have port idx  output  IN_W  index of the currently set out bit.

Function
REQ-013 SHALL implement FSM states IDLE, DIRECT, SCAN.
REQ-014 IDLE -> DIRECT on accepted select with mode=0; IDLE -> SCAN on accepted select with mode=1.
REQ-015 DIRECT -> SCAN and SCAN -> DIRECT when mode changes, evaluated each cycle, effective next cycle, idx retained.
REQ-016 Any state -> IDLE when enable=0; out, out_valid cleared the following cycle.
REQ-017 in_ready SHALL be 1 whenever enable=1, 0 otherwise.
REQ-018 Direct latency: accepted in at edge N -> out = 1<<in, idx = in, out_valid = 1 after edge N.
REQ-019 DIRECT SHALL hold out unchanged until the next accepted select.
REQ-020 SCAN: idx SHALL advance by 1 every DWELL cycles, wrapping OUT_W-1 -> 0; out = 1<<idx.
REQ-021 SCAN: accepted select SHALL reload idx = in and restart dwell count; reload wins over advance in the same cycle.
REQ-022 Exactly one out bit SHALL be set whenever out_valid=1; out SHALL be zero whenever out_valid=0.
REQ-023 Dwell counter width SHALL be $clog2(DWELL)+1; no overflow for any legal DWELL.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, out=0, out_valid=0, idx=0, dwell count=0.
REQ-025 in_ready SHALL be 0 during reset; first acceptance possible on first edge after rst_n deasserts with enable=1.
REQ-026 Reset mid-scan SHALL abandon scan; no resumption of prior idx.

Configuration
REQ-027 Macro DECODER_SCAN_EN SHALL compile SCAN state, dwell counter and mode port logic in.
REQ-028 Without DECODER_SCAN_EN: mode port present but ignored, FSM is IDLE/DIRECT only, DWELL unused.

Structure
REQ-029 Package decoder_pkg SHALL hold the FSM state enum and default values for IN_W and DWELL.
REQ-030 Dwell counter SHALL be sub-module decoder_dwell_cnt (count, terminal pulse, synchronous restart), instantiated only under DECODER_SCAN_EN.

Verification (IN_W=3, DWELL=4, DECODER_SCAN_EN defined)
REQ-031 enable=0, in swept 0..7 with in_valid=1 -> in_ready=0, out=00000000, out_valid=0 throughout.
REQ-032 enable=1, mode=0, in=0..7 one per cycle -> out = 00000001..10000000 one cycle later, idx = in.
REQ-033 mode=1, load in=6 -> out=01000000 for 4 cycles, 10000000 for 4, then wraps to 00000001.
REQ-034 Scan at idx=2 on the dwell terminal cycle, load in=5 same cycle -> idx=5, dwell restarts, no visit of idx=3.
REQ-035 rst_n pulsed low mid-scan at idx=4 -> out=0, out_valid=0 immediately; after release, no output until a new accept.
REQ-036 Scan at idx=3, enable dropped for one cycle -> out=0 next cycle; re-enable with no accept -> stays IDLE, out=0.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and default parameters for the decoder_n_seq block.
//   state_t    - FSM state encoding (IDLE, DIRECT, SCAN)
//   DEF_IN_W   - default select width
//   DEF_DWELL  - default cycles each one-hot position is held in scan mode
package decoder_pkg;

    localparam int unsigned DEF_IN_W  = 3;
    localparam int unsigned DEF_DWELL = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

endpackage : decoder_pkg

// File: rtl/decoder_dwell_cnt.sv
// decoder_dwell_cnt: dwell counter for scan mode. Counts cycles while en=1,
// wraps after DWELL cycles and flags the last cycle of each dwell period.
//   clk, rst_n  - clock, asynchronous active-low reset
//   restart     - synchronous clear to zero (priority over counting)
//   en          - count enable
//   terminal_c  - combinational: high on the last cycle of a dwell period
module decoder_dwell_cnt #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic terminal_c
);

    // One spare bit so DWELL-1 always fits, including DWELL = 1.
    localparam int unsigned CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign terminal_c = en && (cnt == CNT_LAST);

    // Dwell count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= terminal_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : decoder_dwell_cnt

// File: rtl/decoder_n_seq.sv
// decoder_n_seq: registered one-hot decoder with an optional scan (auto-walk) mode.
// Build option: define DECODER_SCAN_EN to include the SCAN state, the dwell
// counter and the mode input; without it mode is ignored and only direct
// decoding is available.
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - output gate; low clears out and returns the FSM to IDLE
//   mode        - 0 = direct decode, 1 = scan
//   in/in_valid - select value offered; in_ready accepts it (high when enabled)
//   out         - registered one-hot decode (zero when not valid)
//   out_valid   - out holds a live one-hot value
//   idx         - index of the currently set out bit
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic [IN_W-1:0]   in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2**IN_W-1:0] out,
    output logic              out_valid,
    output logic [IN_W-1:0]   idx
);

    localparam int unsigned OUT_W = 2 ** IN_W;

    state_t            state, state_n;
    logic [IN_W-1:0]   idx_n;
    logic [OUT_W-1:0]  out_n;
    logic              valid_n;
    logic              accept;
    logic              scan_sel;
    logic              advance;

    // Ready follows enable but is held low while reset is asserted.
    assign in_ready = enable && rst_n;
    assign accept   = in_valid && in_ready;

`ifdef DECODER_SCAN_EN
    logic dwell_restart;
    logic dwell_term_c;

    assign scan_sel      = mode;
    // Counter only runs in SCAN; any reload or entry into SCAN starts a fresh dwell.
    assign dwell_restart = !enable || accept || (state != SCAN);
    assign advance       = dwell_term_c;

    decoder_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (dwell_restart),
        .en         (state == SCAN),
        .terminal_c (dwell_term_c)
    );
`else
    logic                     mode_unused;
    localparam int unsigned   DWELL_UNUSED = DWELL;

    assign mode_unused = mode;
    assign scan_sel    = 1'b0;
    assign advance     = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            out       <= out_n;
            out_valid <= valid_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        out_n   = '0;
        valid_n = 1'b0;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_n   = in;
                        state_n = scan_sel ? SCAN : DIRECT;
                    end
                end
                DIRECT: begin
                    if (accept) begin
                        idx_n = in;
                    end
                    if (scan_sel) begin
                        state_n = SCAN;
                    end
                end
                SCAN: begin
                    // A reload takes priority over the dwell advance.
                    if (accept) begin
                        idx_n = in;
                    end else if (advance) begin
                        idx_n = idx + IN_W'(1);
                    end
                    if (!scan_sel) begin
                        state_n = DIRECT;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (state_n != IDLE) begin
                out_n   = OUT_W'(1) << idx_n;
                valid_n = 1'b1;
            end
        end
    end

endmodule : decoder_n_seq

// File: tb/tb_decoder_n_seq.sv
// tb_decoder_n_seq: self-checking bench for decoder_n_seq (IN_W=3, DWELL=4).
// Direct-decode vectors are table driven; scan-mode sequences are written out
// by hand and are present when DECODER_SCAN_EN is defined.
module tb_decoder_n_seq;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic [2:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic [2:0] idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic       md;
        logic       vld;
        logic [2:0] sel;
        logic       exp_ready;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs [18];

    decoder_n_seq #(
        .IN_W  (3),
        .DWELL (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic m, input logic v, input logic [2:0] s);
        enable   = e;
        mode     = m;
        in_valid = v;
        in       = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [7:0] eo, input logic ev,
                           input logic [2:0] ei);
        total++;
        if (out !== eo || out_valid !== ev || (ev && idx !== ei)) begin
            bad++;
            $display("FAIL %s: got out=%b valid=%b idx=%0d, expected out=%b valid=%b idx=%0d",
                     nm, out, out_valid, idx, eo, ev, ei);
        end
    endtask

    task automatic chk_ready(input string nm, input logic er);
        total++;
        if (in_ready !== er) begin
            bad++;
            $display("FAIL %s: got in_ready=%b expected %b", nm, in_ready, er);
        end
    endtask

    task automatic chk_scan(input string nm, input logic [2:0] ei);
        logic [7:0] one;
        one = 8'b1;
        chk_out(nm, one << ei, 1'b1, ei);
    endtask

    initial begin
        // enable low: nothing accepted, output stays dark
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b0, 1'b0, 1'b1, 3'(i), 1'b0, 8'h00, 1'b0, 3'd0};
        end
        // direct decode, one select per cycle
        for (int i = 0; i < 8; i++) begin
            vecs[8 + i] = '{1'b1, 1'b0, 1'b1, 3'(i), 1'b1, 8'b1 << i, 1'b1, 3'(i)};
        end
        // no select offered: direct output holds
        vecs[16] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h80, 1'b1, 3'd7};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h80, 1'b1, 3'd7};

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 3'd3);
        #12;
        chk_out("reset_state", 8'h00, 1'b0, 3'd0);
        total++;
        if (idx !== 3'd0) begin
            bad++;
            $display("FAIL reset_idx: got %0d expected 0", idx);
        end
        chk_ready("reset_ready", 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].vld, vecs[i].sel);
            #1;
            chk_ready($sformatf("vec%0d_ready", i), vecs[i].exp_ready);
            tick();
            chk_out($sformatf("vec%0d_out", i), vecs[i].exp_out, vecs[i].exp_valid,
                    vecs[i].exp_idx);
        end

`ifdef DECODER_SCAN_EN
        // load 6 in scan: 6 x4, 7 x4, then wrap to 0
        drive(1'b1, 1'b1, 1'b1, 3'd6);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 10; k++) begin
            chk_scan($sformatf("scan_wrap_%0d", k), (k < 4) ? 3'd6 : (k < 8) ? 3'd7 : 3'd0);
            tick();
        end

        // reload on the dwell terminal cycle of idx 2 wins over the advance
        drive(1'b1, 1'b1, 1'b1, 3'd1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int s = 0; s < 8; s++) begin
            chk_scan($sformatf("scan_pre_%0d", s), (s < 4) ? 3'd1 : 3'd2);
            if (s < 7) tick();
        end
        drive(1'b1, 1'b1, 1'b1, 3'd5);
        tick();
        drive(1'b1, 1'b1, 0, 3'd0);
        for (int s = 0; s < 5; s++) begin
            chk_scan($sformatf("scan_reload_%0d", s), (s < 4) ? 3'd5 : 3'd6);
            tick();
        end

        // asynchronous reset mid-scan at idx 4
        drive(1'b1, 1'b1, 1'b1, 3'd4);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        chk_scan("pre_reset", 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("reset_mid_scan", 8'h00, 1'b0, 3'd0);
        chk_ready("reset_mid_ready", 1'b0);
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_out($sformatf("post_reset_%0d", s), 8'h00, 1'b0, 3'd0);
        end
        chk_ready("post_reset_ready", 1'b1);

        // enable dropped for one cycle at idx 3
        drive(1'b1, 1'b1, 1'b1, 3'd3);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        chk_scan("pre_disable", 3'd3);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        #1;
        chk_ready("disable_ready", 1'b0);
        tick();
        chk_out("disable_out", 8'h00, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_out($sformatf("reenable_idle_%0d", s), 8'h00, 1'b0, 3'd0);
        end

        // scan -> direct keeps idx and stops advancing; direct -> scan resumes walk
        drive(1'b1, 1'b1, 1'b1, 3'd2);
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        for (int s = 0; s < 6; s++) begin
            tick();
            chk_scan($sformatf("direct_hold_%0d", s), 3'd2);
        end
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk_scan($sformatf("rescan_%0d", s), (s < 4) ? 3'd2 : 3'd3);
        end
`else
        // without scan support, mode=1 still decodes directly and holds
        drive(1'b1, 1'b1, 1'b1, 3'd4);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int s = 0; s < 6; s++) begin
            chk_scan($sformatf("noscan_hold_%0d", s), 3'd4);
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decoder_n_seq
